// File: rtl/decoder_pkg.sv
// Shared types and helpers for the pipelined N-to-2^N one-hot decoder.
package decoder_pkg;

  // Largest predecode field is 7 bits (IN_W <= 8, HI_W >= 1), so 128 one-hot lines.
  localparam int unsigned PD_MAX_W  = 7;
  localparam int unsigned PD_MAX_N  = 1 << PD_MAX_W;
  localparam int unsigned SEL_MAX_N = 256;

  // Stage-1 predecode payload; fields are sized for the widest legal build
  // and zero-extended, so only the low 2**HI_W / 2**LO_W bits carry data.
  typedef struct packed {
    logic [PD_MAX_N-1:0] hi;
    logic [PD_MAX_N-1:0] lo;
    logic                en;
  } predec_t;

  // Width of the final select word for a given address width.
  function automatic int unsigned OUT_W(input int unsigned in_w);
    return 32'd1 << in_w;
  endfunction

  // Width of the lower predecode field.
  function automatic int unsigned LO_W(input int unsigned in_w, input int unsigned hi_w);
    return in_w - hi_w;
  endfunction

  // True when at most one bit of v is set.
  function automatic logic onehot0(input logic [SEL_MAX_N-1:0] v);
    return (v & (v - SEL_MAX_N'(1))) == '0;
  endfunction

endpackage

// File: rtl/predec_n.sv
// Combinational W-to-2^W one-hot decoder with enable (all zeros when disabled).
module predec_n #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0]      addr_i,
  input  logic              en_i,
  output logic [(1<<W)-1:0] onehot_c
);

  // Single set bit at the addressed position, gated by the enable.
  always_comb begin
    onehot_c         = '0;
    onehot_c[addr_i] = en_i;
  end

endmodule

// File: rtl/pipe_decoder_n.sv
// Two-stage pipelined N-to-2^N one-hot decoder with valid/ready flow control.
// Stage 1 predecodes the address into hi/lo one-hot fields, stage 2 ANDs them
// into the final select word. Optional one-hot self-check is enabled by
// defining PIPE_DECODER_ONEHOT_CHK_EN; otherwise err_flag is tied low.
module pipe_decoder_n
  import decoder_pkg::*;
#(
  parameter int unsigned IN_W = 5,
  parameter int unsigned HI_W = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_addr,
  input  logic                    in_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [(1<<IN_W)-1:0]    out_sel,
  output logic                    err_flag
);

  localparam int unsigned LW    = LO_W(IN_W, HI_W);
  localparam int unsigned SEL_W = OUT_W(IN_W);
  localparam int unsigned HI_N  = 1 << HI_W;
  localparam int unsigned LO_N  = 1 << LW;

  logic [HI_N-1:0]  hi_c;
  logic [LO_N-1:0]  lo_c;
  logic             s1_adv_c;
  logic             s2_adv_c;
  logic             v1_q;
  logic             v2_q;
  predec_t          s1_q;
  predec_t          s1_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic             unused_s1;

  // Upper field carries the enable so a disabled beat decodes to all zeros.
  predec_n #(.W(HI_W)) u_predec_hi (
    .addr_i   (in_addr[IN_W-1:LW]),
    .en_i     (in_en),
    .onehot_c (hi_c)
  );

  predec_n #(.W(LW)) u_predec_lo (
    .addr_i   (in_addr[LW-1:0]),
    .en_i     (1'b1),
    .onehot_c (lo_c)
  );

  // Flow control: a stage advances when it is empty or its successor advances.
  always_comb begin
    s2_adv_c = !v2_q || out_ready;
    s1_adv_c = !v1_q || s2_adv_c;
  end

  assign in_ready = s1_adv_c;

  // Stage-1 payload; empty beats load zeros.
  always_comb begin
    s1_d = '0;
    if (in_valid) begin
      s1_d.hi = PD_MAX_N'(hi_c);
      s1_d.lo = PD_MAX_N'(lo_c);
`ifdef PIPE_DECODER_ONEHOT_CHK_EN
      s1_d.en = in_en;
`endif
    end
  end

  // Stage-2 combine: out_sel[h*LO_N+l] = hi[h] & lo[l]; zero when stage 1 is empty.
  always_comb begin
    sel_d = '0;
    if (v1_q) begin
      for (int unsigned h = 0; h < HI_N; h++) begin
        for (int unsigned l = 0; l < LO_N; l++) begin
          sel_d[h*LO_N + l] = s1_q.hi[h] & s1_q.lo[l];
        end
      end
    end
  end

  // Stage-1 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else if (s1_adv_c) begin
      v1_q <= in_valid;
      s1_q <= s1_d;
    end
  end

  // Stage-2 register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_q  <= 1'b0;
      sel_q <= '0;
    end else if (s2_adv_c) begin
      v2_q  <= v1_q;
      sel_q <= sel_d;
    end
  end

  assign out_valid = v2_q;
  assign out_sel   = sel_q;

  // Padding bits of the predecode struct (and en when the checker is absent) are not consumed.
  assign unused_s1 = ^{s1_q.hi, s1_q.lo, s1_q.en};

`ifdef PIPE_DECODER_ONEHOT_CHK_EN
  logic en2_q;
  logic chk_bad_c;
  logic err_q;

  // Enable travels alongside the stage-2 beat for the checker.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en2_q <= 1'b0;
    end else if (s2_adv_c) begin
      en2_q <= v1_q & s1_q.en;
    end
  end

  // A valid beat must be exactly one-hot when enabled and all-zero when disabled.
  always_comb begin
    chk_bad_c = 1'b0;
    if (v2_q) begin
      if (en2_q) begin
        chk_bad_c = !onehot0(SEL_MAX_N'(sel_q)) || (sel_q == '0);
      end else begin
        chk_bad_c = (sel_q != '0);
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | chk_bad_c;
    end
  end

  assign err_flag = err_q;
`else
  assign err_flag = 1'b0;
`endif

endmodule
